l2_arbiter: RTL

- Shares the single unified L2 cache port between the L1 instruction-cache miss path and the L1 data-cache miss/writeback path.
- Accepts 256-bit cacheline read requests from I and read/write requests from D, and grants one requester at a time.
- Drives the L2 cpu-side mem_read/mem_write/address/wdata interface with registered outputs, and routes the one-cycle L2 resp back to the granted requester.
- Sits between the L1 caches and the L2 controller; the L2 side treats read and write asserted together as a no-op, so the arbiter never does that.

---
 rtl/l2_arb_pkg.sv | 19 +
 rtl/l2_arb_pick.sv | 55 +++++
 rtl/l2_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/l2_arb_pkg.sv
// Shared types and defaults for the L1-to-L2 port arbiter.
package l2_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_I,
    GNT_D
  } grant_t;

endpackage

// File: rtl/l2_arb_pick.sv
// Winner selection between the I-cache and D-cache requesters.
// Build option: define L2_ARB_RR_EN to alternate ties using a last-grant
// register; otherwise D always beats I and no last-grant state exists.
module l2_arb_pick
  import l2_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_read,
  input  logic   d_valid,
  input  logic   update,
  input  grant_t granted,
  output grant_t winner
);

`ifdef L2_ARB_RR_EN
  grant_t last_grant;

  // Remember who was served last so that ties alternate; I first, so D wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= GNT_I;
    end else if (update) begin
      last_grant <= granted;
    end
  end

  // On a tie grant the requester that was not served last.
  always_comb begin
    winner = GNT_NONE;
    if (i_read && d_valid) begin
      winner = (last_grant == GNT_D) ? GNT_I : GNT_D;
    end else if (d_valid) begin
      winner = GNT_D;
    end else if (i_read) begin
      winner = GNT_I;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst, update, granted};

  // Fixed priority: a valid D request always beats I.
  always_comb begin
    // NOTE: default assignment first so no path leaves winner unassigned (no latch).
    winner = GNT_NONE;
    if (d_valid) begin
      winner = GNT_D;
    end else if (i_read) begin
      winner = GNT_I;
    end
  end
`endif

endmodule

// File: rtl/l2_arbiter.sv
// Shares the unified L2 port between the I-cache miss path and the D-cache
// miss/writeback path. One transaction at a time: IDLE -> BUSY -> RELEASE.
// Build option L2_ARB_RR_EN (handled inside l2_arb_pick) selects
// round-robin tie breaking instead of fixed D-over-I priority.
module l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] l2_addr,
  output logic              l2_read,
  output logic              l2_write,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  arb_state_t state;
  arb_state_t next_state;
  grant_t     grant;
  grant_t     winner;
  logic       d_valid;
  logic       load;
  logic       done;

  // Read and write together is illegal from D; such a request is simply invisible.
  assign d_valid = d_read ^ d_write;

  l2_arb_pick u_pick (
    .clk     (clk),
    .rst     (rst),
    .i_read  (i_read),
    .d_valid (d_valid),
    .update  (done),
    .granted (grant),
    .winner  (winner)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, whatever the block order.
      state <= next_state;
    end
  end

  // Next state: arbitrate only in IDLE, wait for L2 in BUSY, one dead cycle in RELEASE.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (winner != GNT_NONE) next_state = BUSY;
      BUSY:    if (l2_resp)            next_state = RELEASE;
      RELEASE:                         next_state = IDLE;
      default:                         next_state = IDLE;
    endcase
  end

  // Outputs: transaction strobes and the routed one-cycle completions.
  always_comb begin
    load   = (state == IDLE) && (winner != GNT_NONE);
    done   = (state == BUSY) && l2_resp;
    i_resp = done && (grant == GNT_I);
    d_resp = done && (grant == GNT_D);
  end

  // Grant owner for the duration of one transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant <= GNT_NONE;
    end else if (load) begin
      grant <= winner;
    end else if (done) begin
      grant <= GNT_NONE;
    end
  end

  // Registered L2 request; frozen while BUSY, read/write dropped on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l2_addr  <= '0;
      l2_read  <= 1'b0;
      l2_write <= 1'b0;
      // NOTE: the line register is reset because L2 must see a defined bus after reset.
      l2_wdata <= '0;
    end else if (load) begin
      l2_addr  <= (winner == GNT_D) ? d_addr : i_addr;
      l2_read  <= (winner == GNT_I) || ((winner == GNT_D) && d_read);
      l2_write <= (winner == GNT_D) && d_write;
      if ((winner == GNT_D) && d_write) begin
        l2_wdata <= d_wdata;
      end
    end else if (done) begin
      l2_read  <= 1'b0;
      l2_write <= 1'b0;
    end
  end

  // Read data is broadcast; only the resp strobes are routed.
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

endmodule
